// File: rtl/scan_seq.sv
// Scan test sequencer: serially loads a pattern, pulses one functional capture,
// unloads the chain into response, then compares against the expected bits.
module scan_seq #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   chain_len,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [MAX_LEN-1:0] expected,
  input  logic               scan_out0,
  output logic               scan_in0,
  output logic               scan_en,
  output logic               test_mode,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               err,
  output logic [MAX_LEN-1:0] response
);
  localparam int KW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CAPTURE, S_UNLOAD, S_DONE} state_t;

  state_t             state, state_n;
  logic [LEN_W-1:0]   k, k_n, len_m1;
  logic [MAX_LEN-1:0] pat_q, exp_q, mask, pat_n, resp_n;
  logic               accept, reject, len_ok, last;
  logic               scan_in0_n, scan_en_n, busy_n, done_n, pass_n;

  // Expected bits beyond the active length are zeroed at latch time, so the
  // final compare can be a plain equality against the zero-padded response.
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < chain_len);
  end

  assign len_ok = (chain_len != '0) && (chain_len <= LEN_W'(MAX_LEN));
  assign last   = (k == len_m1);

  // State register plus registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      k         <= '0;
      len_m1    <= '0;
      pat_q     <= '0;
      exp_q     <= '0;
      scan_in0  <= 1'b0;
      scan_en   <= 1'b0;
      test_mode <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err       <= 1'b0;
      response  <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      if (accept) begin
        len_m1 <= chain_len - LEN_W'(1);
        pat_q  <= pattern;
        exp_q  <= expected & mask;
      end
      scan_in0  <= scan_in0_n;
      scan_en   <= scan_en_n;
      test_mode <= busy_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err       <= reject;
      response  <= resp_n;
    end
  end

  // Next-state; k holds at len-1 so it never wraps even at MAX_LEN
  always_comb begin
    state_n = state;
    k_n     = k;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        if (len_ok) begin
          accept  = 1'b1;
          state_n = S_SHIFT;
          k_n     = '0;
        end else begin
          reject = 1'b1;
        end
      end
      S_SHIFT:   if (last) state_n = S_CAPTURE; else k_n = k + LEN_W'(1);
      S_CAPTURE: begin state_n = S_UNLOAD; k_n = '0; end
      S_UNLOAD:  if (last) state_n = S_DONE; else k_n = k + LEN_W'(1);
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      k_n     = k;
    end
  end

  // Output values for the next cycle, decoded from the next state
  always_comb begin
    pat_n  = accept ? pattern : pat_q;
    resp_n = response;
    if (accept)
      resp_n = '0;
    else if (state == S_UNLOAD && !abort)
      resp_n[k[KW-1:0]] = scan_out0;
    pass_n = pass;
    if (accept) pass_n = 1'b0;
    if (state_n == S_DONE) pass_n = (resp_n == exp_q);
    if (abort && state != S_IDLE) pass_n = 1'b0;
    scan_in0_n = (state_n == S_SHIFT) ? pat_n[k_n[KW-1:0]] : 1'b0;
    scan_en_n  = (state_n == S_SHIFT) || (state_n == S_UNLOAD);
    busy_n     = (state_n != S_IDLE);
    done_n     = (state_n == S_DONE);
  end
endmodule

// File: tb/tb_scan_seq.sv
// Directed + randomized bench for scan_seq with a variable-length behavioural
// scan chain and a transaction-level reference for latency, response and pass.
module tb_scan_seq;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;

  logic               clk = 1'b0;
  logic               reset, start, abort, scan_out0;
  logic [LEN_W-1:0]   chain_len;
  logic [MAX_LEN-1:0] pattern, expected, response;
  logic               scan_in0, scan_en, test_mode, busy, done, pass, err;

  int cmp   = 0;
  int fails = 0;

  // Behavioural chain: cl active flops, scan_in0 enters at cl-1, scan_out0 = flop 0
  int          cl = 4;
  logic [63:0] chain = '0, cap = '0, snap = '0;

  scan_seq #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .chain_len(chain_len),
    .pattern(pattern), .expected(expected), .scan_out0(scan_out0),
    .scan_in0(scan_in0), .scan_en(scan_en), .test_mode(test_mode), .busy(busy),
    .done(done), .pass(pass), .err(err), .response(response)
  );

  always #5 clk = ~clk;

  assign scan_out0 = chain[0];

  always @(posedge clk) begin
    if (test_mode && scan_en)
      chain <= ((chain >> 1) & ~(64'd1 << (cl - 1))) | (64'(scan_in0) << (cl - 1));
    else if (test_mode && !scan_en && !done) begin
      snap  <= chain;
      chain <= cap;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction checked against the reference rules:
  // done at cycle 2L+2, scan_en high 2L cycles and low 1 while busy,
  // response = captured value, pass = masked equality with expected.
  task automatic run_seq(input int L, input logic [63:0] pat, input logic [63:0] exp,
                         input logic [63:0] cp, input bit ab_start, input bit restart);
    logic [63:0] mask;
    bit   exp_pass, got;
    int   n, hi, lo, errs;
    mask     = (L == 64) ? '1 : ((64'd1 << L) - 64'd1);
    exp_pass = (((cp ^ exp) & mask) == 64'd0);
    cl = L; cap = cp;
    chain_len = LEN_W'(L); pattern = pat; expected = exp;
    start = 1'b1; abort = ab_start;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n = 1; hi = 0; lo = 0; errs = 0; got = 1'b0;
    while (n <= 200) begin
      if (err) errs++;
      if (done) begin got = 1'b1; break; end
      if (scan_en) hi++; else lo++;
      if (restart && n == 3) begin start = 1'b1; chain_len = '0; pattern = ~pat; end
      else if (restart && n == 4) start = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("latency", 64'(n), 64'(2 * L + 2));
    chk("pass", 64'(pass), 64'(exp_pass));
    chk("response", response, cp & mask);
    chk("shift_in", snap & mask, pat & mask);
    chk("en_high", 64'(hi), 64'(2 * L));
    chk("en_low", 64'(lo), 64'd1);
    chk("no_err", 64'(errs), 64'd0);
    @(negedge clk);
    chk("idle_after", {60'd0, busy, done, test_mode, scan_en}, 64'd0);
    chk("pass_hold", 64'(pass), 64'(exp_pass));
  endtask

  initial begin
    int          bad [2];
    int          d, L;
    logic [63:0] pat, cp, ex;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    chain_len = '0; pattern = '0; expected = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {57'd0, scan_in0, scan_en, test_mode, busy, done, pass, err}, 64'd0);
    chk("reset_resp", response, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Reference transactions on a 4-flop chain capturing 0110
    run_seq(4, 64'b1011, 64'b0110, 64'b0110, 1'b0, 1'b0);
    run_seq(4, 64'b1011, 64'b0111, 64'b0110, 1'b0, 1'b0);

    // Illegal lengths
    bad[0] = 0; bad[1] = MAX_LEN + 1;
    foreach (bad[i]) begin
      chain_len = LEN_W'(bad[i]); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", {62'd0, err, busy}, 64'b10);
      @(negedge clk);
      chk("err_clear", {62'd0, err, busy}, 64'b00);
    end

    // Abort in UNLOAD with k=2 (cycle 8 of a len-4 sequence)
    cl = 4; cap = 64'b0110; chain_len = 4; pattern = 64'b1011; expected = 64'b0110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {60'd0, busy, test_mode, scan_en, done}, 64'd0);
    chk("abort_pass", 64'(pass), 64'd0);
    chk("abort_resp", response, 64'b10);
    d = 0;
    repeat (12) begin @(negedge clk); if (done) d++; end
    chk("abort_no_done", 64'(d), 64'd0);

    // Reset mid-SHIFT, then a clean sequence
    chain_len = 4; pattern = 64'b1011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_outs", {57'd0, scan_in0, scan_en, test_mode, busy, done, pass, err}, 64'd0);
    chk("rst_mid_resp", response, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_seq(4, 64'b1011, 64'b0110, 64'b0110, 1'b0, 1'b0);

    // Full-length chain
    pat = {$urandom, $urandom}; cp = {$urandom, $urandom};
    run_seq(64, pat, cp, cp, 1'b0, 1'b0);

    // Randomized transactions; also start+abort in IDLE and start while busy
    repeat (6) begin
      L   = int'($urandom_range(1, 64));
      pat = {$urandom, $urandom};
      cp  = {$urandom, $urandom};
      ex  = ($urandom_range(0, 1) == 1) ? cp : (cp ^ (64'd1 << $urandom_range(0, L - 1)));
      run_seq(L, pat, ex, cp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
